sim_ctrl_slv: RTL and testbench
===============================

Name: sim_ctrl_slv

Overview:
- Memory-mapped simulation-control responder inside soc_top; it is the DUT-side end of the testbench finish-monitor handshake.
- Each RV core writes a per-hart TOHOST word to report pass or fail.
- The block aggregates the per-hart results, runs a cycle counter and watchdog, and drives the sim_finish/sim_pass/sim_code outputs that the testbench finish monitor samples.

Parameters:
- NUM_HART, 3, number of reporting harts (1..8).
- ADDR_W, 8, byte-address width of the register window.
- DRAIN_CYCLES, 16, cycles between last hart done and sim_finish assertion.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  single clock.
- sys_rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address, word aligned.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  32  read data; 0 for writes.
- sim_finish  out  1  level; stays high once set.
- sim_pass  out  1  valid when sim_finish=1.
- sim_code  out  32  first failing TOHOST value, or 0xDEAD_0000 on timeout.
- putc_valid  out  1  console byte strobe.
- putc_data  out  8  console byte.

Behaviour:
- Reset values: all outputs 0, all registers 0, FSM=RUN.
- Handshake:
  - req_ready = !rsp_valid | rsp_ready.
  - An accepted request produces rsp_valid the next cycle.
  - rsp_valid holds, with rsp_rdata stable, until rsp_ready.
  - At most one response is outstanding.
- Register map (byte offsets):
  - 0x00+4*h, TOHOST[h], RW. A write with bit0=1 marks hart h done. Value 1 means pass; any other odd value means fail.
  - Rewrites after hart h is done are ignored; the first report wins.
  - 0x40 CYCLE_LO, RO.
  - 0x44 CYCLE_HI, RO. Reading CYCLE_LO snapshots the high word into CYCLE_HI.
  - 0x48 STATUS, RO: [7:0] done_mask, [15:8] fail_mask, [17:16] FSM state.
  - 0x4C PUTC, WO; see Optional Feature.
  - Unmapped reads return 0 and unmapped writes are ignored; no error response.
- Cycle counter: 64-bit, increments every cycle from reset release, wraps silently.
- FSM:
  - RUN → DRAIN when done_mask == all ones. Drain counter loads DRAIN_CYCLES.
  - RUN → TIMEOUT when TIMEOUT_CYCLES≠0 and counter[31:0] == TIMEOUT_CYCLES−1.
  - DRAIN: counts down by 1 per cycle; at 0 → FINISH.
  - FINISH: sim_finish=1, sim_pass = (fail_mask==0). sim_code = TOHOST of the lowest-index failing hart, or 1 if all passed.
  - TIMEOUT: sim_finish=1, sim_pass=0, sim_code=0xDEAD_0000.
  - FINISH and TIMEOUT are terminal until reset. Register accesses remain serviced in all states.
- Simultaneous events: if the final TOHOST write and the timeout hit in the same cycle, done wins (→ DRAIN).
- DRAIN_CYCLES=0: FINISH is entered the cycle after DRAIN is entered.
- Mid-operation reset: asynchronously clears everything, including the pending response and sim_finish.

Optional Feature:
- Macro: SIM_CTRL_PUTC_EN.
- Defined:
  - A write to 0x4C pulses putc_valid for one cycle, in the cycle after acceptance, with putc_data=wdata[7:0].
  - Back-to-back writes give back-to-back pulses.
- Undefined:
  - Writes to 0x4C are ignored.
  - putc_valid and putc_data are tied to 0.
  - The ports remain present.

Test Plan:
- All pass: write 0x1 to 0x00, 0x04, 0x08 → after the last write, sim_finish rises exactly DRAIN_CYCLES+1 cycles later; sim_pass=1, sim_code=1.
- One fail: hart1 writes 0x7, the others write 0x1 → sim_pass=0, sim_code=0x7, STATUS[15:8]=0x02. A later rewrite of 0x04 with 0x1 leaves sim_code unchanged.
- Timeout: TIMEOUT_CYCLES=100, no writes → sim_finish at cycle 100, sim_code=0xDEAD_0000, STATUS[17:16]=TIMEOUT.
- Backpressure: read 0x40 with rsp_ready held low for 5 cycles → req_ready=0 and rsp_rdata stable for those 5 cycles. The read of 0x44 returns the snapshot taken with that 0x40 read.
- PUTC: with SIM_CTRL_PUTC_EN, write 0x48 then 0x49 back-to-back to 0x4C → two consecutive putc_valid pulses carrying 'H','I'. Without the macro, no pulses.
- Reset mid-DRAIN: assert sys_rst during DRAIN → all outputs 0 immediately; STATUS reads 0 after release.

Source files
------------

// File: rtl/sim_ctrl_slv.sv
// Simulation-control register slave: per-hart TOHOST aggregation, cycle counter,
// watchdog and finish handshake. Define SIM_CTRL_PUTC_EN to enable the PUTC console port.
module sim_ctrl_slv #(
  parameter int unsigned NUM_HART       = 3,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              sim_finish,
  output logic              sim_pass,
  output logic [31:0]       sim_code,
  output logic              putc_valid,
  output logic [7:0]        putc_data
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CYC_W   = 64;
  localparam int unsigned DRAIN_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CYC_LO = ADDR_W'(32'h40);
  localparam logic [ADDR_W-1:0] ADDR_CYC_HI = ADDR_W'(32'h44);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h48);
  localparam logic [ADDR_W-1:0] ADDR_PUTC   = ADDR_W'(32'h4C);

  localparam logic [DATA_W-1:0] TIMEOUT_CODE = 32'hDEAD_0000;
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_FINISH  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [CYC_W-1:0]     cycle_q;
  logic [DATA_W-1:0]    cyc_hi_q;
  logic [DATA_W-1:0]    tohost_q [NUM_HART];
  logic [NUM_HART-1:0]  done_q;
  logic [NUM_HART-1:0]  fail_c;
  logic [NUM_HART-1:0]  tohost_we_c;
  logic [NUM_HART-1:0]  done_set_c;
  logic                 all_done_c;
  logic                 acc_c;
  logic                 wr_acc_c;
  logic                 rd_acc_c;
  logic [DATA_W-1:0]    rdata_c;
  logic [DATA_W-1:0]    fail_code_c;
  logic                 finish_d;
  logic                 pass_d;
  logic [DATA_W-1:0]    code_d;

  assign req_ready = !rsp_valid || rsp_ready;
  assign acc_c     = req_valid && req_ready;
  assign wr_acc_c  = acc_c && req_write;
  assign rd_acc_c  = acc_c && !req_write;

  // TOHOST write decode; a hart's word freezes once it has reported done
  always_comb begin
    tohost_we_c = '0;
    done_set_c  = '0;
    for (int unsigned h = 0; h < NUM_HART; h++) begin
      if (wr_acc_c && req_addr == ADDR_W'(4 * h) && !done_q[h]) begin
        tohost_we_c[h] = 1'b1;
        done_set_c[h]  = req_wdata[0];
      end
    end
  end

  // Includes the write landing this cycle so a final report beats a same-cycle timeout
  assign all_done_c = &(done_q | done_set_c);

  always_comb begin
    fail_c      = '0;
    fail_code_c = 32'd1;
    for (int unsigned h = 0; h < NUM_HART; h++) begin
      fail_c[h] = done_q[h] && (tohost_q[h] != 32'd1);
    end
    for (int unsigned i = 0; i < NUM_HART; i++) begin
      if (fail_c[NUM_HART-1-i]) fail_code_c = tohost_q[NUM_HART-1-i];
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    for (int unsigned h = 0; h < NUM_HART; h++) begin
      if (req_addr == ADDR_W'(4 * h)) rdata_c = tohost_q[h];
    end
    case (req_addr)
      ADDR_CYC_LO: rdata_c = cycle_q[31:0];
      ADDR_CYC_HI: rdata_c = cyc_hi_q;
      ADDR_STATUS: rdata_c = {14'd0, state_q, 8'(fail_c), 8'(done_q)};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      cycle_q  <= '0;
      cyc_hi_q <= '0;
      done_q   <= '0;
      for (int unsigned h = 0; h < NUM_HART; h++) tohost_q[h] <= '0;
    end else begin
      cycle_q <= cycle_q + CYC_W'(1);
      done_q  <= done_q | done_set_c;
      for (int unsigned h = 0; h < NUM_HART; h++) begin
        if (tohost_we_c[h]) tohost_q[h] <= req_wdata;
      end
      if (rd_acc_c && req_addr == ADDR_CYC_LO) cyc_hi_q <= cycle_q[63:32];
    end
  end

  // Single outstanding response; rdata holds until the consumer takes it
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (acc_c) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_write ? '0 : rdata_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_RUN;
      drain_q    <= '0;
      sim_finish <= 1'b0;
      sim_pass   <= 1'b0;
      sim_code   <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      sim_finish <= finish_d;
      sim_pass   <= pass_d;
      sim_code   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    finish_d = sim_finish;
    pass_d   = sim_pass;
    code_d   = sim_code;
    case (state_q)
      ST_RUN: begin
        if (all_done_c) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else if (TIMEOUT_CYCLES != 0 && cycle_q[31:0] == TIMEOUT_LAST) begin
          state_d  = ST_TIMEOUT;
          finish_d = 1'b1;
          pass_d   = 1'b0;
          code_d   = TIMEOUT_CODE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d  = ST_FINISH;
          finish_d = 1'b1;
          pass_d   = (fail_c == '0);
          code_d   = fail_code_c;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef SIM_CTRL_PUTC_EN
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      putc_valid <= 1'b0;
      putc_data  <= '0;
    end else begin
      putc_valid <= wr_acc_c && req_addr == ADDR_PUTC;
      if (wr_acc_c && req_addr == ADDR_PUTC) putc_data <= req_wdata[7:0];
    end
  end
`else
  assign putc_valid = 1'b0;
  assign putc_data  = '0;
`endif

endmodule

// File: tb/tb_sim_ctrl_slv.sv
// Directed self-checking bench for sim_ctrl_slv (DRAIN_CYCLES=16, TIMEOUT_CYCLES=100).
module tb_sim_ctrl_slv;

  localparam int unsigned DRAIN = 16;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        sim_finish;
  logic        sim_pass;
  logic [31:0] sim_code;
  logic        putc_valid;
  logic [7:0]  putc_data;

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  int rel_cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  sim_ctrl_slv #(
    .NUM_HART(3), .ADDR_W(8), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sim_finish(sim_finish), .sim_pass(sim_pass), .sim_code(sim_code),
    .putc_valid(putc_valid), .putc_data(putc_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step(2);
    sys_rst = 1'b0;
    rel_cyc = tb_cyc;
  endtask

  // One request; returns just after the accepting edge with the response in view
  task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int g = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && g < 20) begin
      step(1);
      g++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    step(1);
    acc_cyc   = tb_cyc;
    req_valid = 1'b0;
    rd        = rsp_rdata;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, addr, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, addr, 32'd0, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic wait_finish();
    int g = 0;
    while (!sim_finish && g < 300) begin
      step(1);
      g++;
    end
    check("finish_seen", 64'(sim_finish), 64'd1);
  endtask

  initial begin
    logic [31:0] v0;
    int last;

    #1 sys_rst = 1'b1;
    #2;
    check("rst_finish", 64'(sim_finish), 64'd0);
    check("rst_pass",   64'(sim_pass),   64'd0);
    check("rst_code",   64'(sim_code),   64'd0);
    check("rst_rsp_v",  64'(rsp_valid),  64'd0);
    check("rst_rdata",  64'(rsp_rdata),  64'd0);
    check("rst_putc",   64'(putc_valid), 64'd0);
    @(posedge clk);
    #1;

    // All harts pass
    do_reset();
    rd_chk("unmapped_rd", 8'h3C, 32'd0);
    wr(8'h00, 32'd1);
    wr(8'h04, 32'd1);
    wr(8'h08, 32'd1);
    last = acc_cyc;
    wait_finish();
    check("pass_latency", 64'(tb_cyc - last), 64'(DRAIN + 1));
    check("pass_pass", 64'(sim_pass), 64'd1);
    check("pass_code", 64'(sim_code), 64'd1);
    rd_chk("pass_status", 8'h48, 32'h0002_0007);

    // Hart1 fails, later rewrite ignored
    do_reset();
    wr(8'h00, 32'd1);
    wr(8'h04, 32'd7);
    wr(8'h08, 32'd1);
    rd_chk("fail_status_drain", 8'h48, 32'h0001_0207);
    wr(8'h04, 32'd1);
    rd_chk("fail_rewrite_rd", 8'h04, 32'd7);
    wait_finish();
    check("fail_pass", 64'(sim_pass), 64'd0);
    check("fail_code", 64'(sim_code), 64'd7);
    rd_chk("fail_status_fin", 8'h48, 32'h0002_0207);

    // Watchdog timeout with no reports
    do_reset();
    wait_finish();
    check("tmo_cycle", 64'(tb_cyc - rel_cyc), 64'(TMO));
    check("tmo_pass", 64'(sim_pass), 64'd0);
    check("tmo_code", 64'(sim_code), 64'hDEAD_0000);
    rd_chk("tmo_status", 8'h48, 32'h0003_0000);

    // Response backpressure and CYCLE_HI snapshot
    do_reset();
    step(3);
    rsp_ready = 1'b0;
    bus(1'b0, 8'h40, 32'd0, v0);
    check("cyc_lo", 64'(v0), 64'(acc_cyc - rel_cyc - 1));
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rdata",     64'(rsp_rdata), 64'(v0));
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    check("bp_retired", 64'(rsp_valid), 64'd0);
    rd_chk("cyc_hi_snap", 8'h44, 32'd0);

    // Console port
    do_reset();
    wr(8'h4C, 32'h0000_0148);
`ifdef SIM_CTRL_PUTC_EN
    check("putc_v0", 64'(putc_valid), 64'd1);
    check("putc_d0", 64'(putc_data),  64'h48);
`else
    check("putc_v0", 64'(putc_valid), 64'd0);
    check("putc_d0", 64'(putc_data),  64'h00);
`endif
    wr(8'h4C, 32'h0000_0049);
`ifdef SIM_CTRL_PUTC_EN
    check("putc_v1", 64'(putc_valid), 64'd1);
    check("putc_d1", 64'(putc_data),  64'h49);
`else
    check("putc_v1", 64'(putc_valid), 64'd0);
    check("putc_d1", 64'(putc_data),  64'h00);
`endif
    step(1);
    check("putc_idle", 64'(putc_valid), 64'd0);

    // Reset asserted during DRAIN with a response pending
    do_reset();
    wr(8'h00, 32'd1);
    wr(8'h04, 32'd1);
    wr(8'h08, 32'd1);
    step(3);
    rsp_ready = 1'b0;
    bus(1'b0, 8'h48, 32'd0, v0);
    check("drain_status", 64'(v0), 64'h0001_0007);
    #2 sys_rst = 1'b1;
    #1;
    check("mid_rst_rsp_v",  64'(rsp_valid),  64'd0);
    check("mid_rst_rdata",  64'(rsp_rdata),  64'd0);
    check("mid_rst_finish", 64'(sim_finish), 64'd0);
    check("mid_rst_ready",  64'(req_ready),  64'd1);
    @(posedge clk);
    #1;
    do_reset();
    rd_chk("post_rst_status", 8'h48, 32'd0);
    step(DRAIN + 4);
    check("post_rst_no_fin", 64'(sim_finish), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
